// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle between the PC/IF-ID unit, the instruction cache, decode and execute.
// FETCH_PERF_CNT_EN adds the FetchCount/StallCount performance counters.
interface fetch_pc_unit_if #(
    parameter int dataW = 32
);
    logic             InsCacheStall;
    logic [dataW-1:0] InsIn;
    logic             DecodeHold;
    logic             RedirectValid;
    logic [dataW-1:0] RedirectTarget;
    logic [dataW-1:0] ProgAddr;
    logic [dataW-1:0] IfIdIns;
    logic [dataW-1:0] IfIdPC;
    logic             IfIdValid;
    logic             MisalignFault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      FetchCount;
    logic [31:0]      StallCount;
`endif

    modport slave (
        input  InsCacheStall, InsIn, DecodeHold, RedirectValid, RedirectTarget,
`ifdef FETCH_PERF_CNT_EN
        output FetchCount, StallCount,
`endif
        output ProgAddr, IfIdIns, IfIdPC, IfIdValid, MisalignFault
    );

    modport master (
        output InsCacheStall, InsIn, DecodeHold, RedirectValid, RedirectTarget,
`ifdef FETCH_PERF_CNT_EN
        input  FetchCount, StallCount,
`endif
        input  ProgAddr, IfIdIns, IfIdPC, IfIdValid, MisalignFault
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter plus valid-tagged IF/ID register; honours cache stalls, decode holds and redirects.
// Define FETCH_PERF_CNT_EN to add the FetchCount/StallCount counters.
module fetch_pc_unit #(
    parameter int               dataW       = 32,
    parameter logic [dataW-1:0] ResetVector = '0
) (
    input  logic               clock,
    input  logic               reset,
    fetch_pc_unit_if.slave     bus
);
    localparam logic [dataW-1:0] NOP = dataW'(32'h00000013);

    // The PC is held as a word index so the two low address bits can never be nonzero.
    logic [dataW-3:0] r_pc_word;
    logic [dataW-1:0] r_ifid_ins;
    logic [dataW-1:0] r_ifid_pc;
    logic             r_ifid_valid;
    logic             r_misalign;
    logic [dataW-1:0] w_prog_addr;
    logic             w_target_aligned;
    logic             w_ifid_load;

    assign w_prog_addr      = {r_pc_word, 2'b00};
    assign w_target_aligned = (bus.RedirectTarget[1:0] == 2'b00);
    assign w_ifid_load      = !bus.RedirectValid && !bus.DecodeHold && !bus.InsCacheStall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc_word <= ResetVector[dataW-1:2];
            r_misalign <= 1'b0;
        end else if (bus.RedirectValid) begin
            if (w_target_aligned) begin
                r_pc_word <= bus.RedirectTarget[dataW-1:2];
            end else begin
                r_pc_word  <= ResetVector[dataW-1:2];
                r_misalign <= 1'b1;
            end
        end else if (!(bus.DecodeHold || bus.InsCacheStall)) begin
            r_pc_word <= r_pc_word + 1'b1;
        end
    end

    // Redirect flush outranks a decode hold; a cache stall only bubbles when decode is not holding.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ifid_ins   <= NOP;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (bus.RedirectValid) begin
            r_ifid_ins   <= NOP;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (bus.DecodeHold) begin
            r_ifid_ins   <= r_ifid_ins;
        end else if (bus.InsCacheStall) begin
            r_ifid_ins   <= NOP;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_ins   <= bus.InsIn;
            r_ifid_pc    <= w_prog_addr;
            r_ifid_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_ifid_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (bus.InsCacheStall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.FetchCount = r_fetch_cnt;
    assign bus.StallCount = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_ifid_load;
`endif

    assign bus.ProgAddr      = w_prog_addr;
    assign bus.IfIdIns       = r_ifid_ins;
    assign bus.IfIdPC        = r_ifid_pc;
    assign bus.IfIdValid     = r_ifid_valid;
    assign bus.MisalignFault = r_misalign;
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program counter and IF/ID pipeline register sitting directly upstream of the instruction cache and downstream of it toward the decoder.
- Drives ProgAddr into the cache and honours the cache's stall output.
- Captures the cache's OutputIns together with its PC into a valid-tagged IF/ID register for the decoder.
- Accepts branch/jump redirects from execute and hazard holds from decode.

Parameters:
- dataW, 32, datapath and address width
- ResetVector, 32'h00000000, PC value loaded on reset

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- InsCacheStall  input  1  high while the instruction cache refreshes; PC must hold
- InsIn  input  dataW  instruction from the cache (OutputIns); NOP while the cache stalls
- DecodeHold  input  1  decode/hazard unit requests IF/ID and PC hold
- RedirectValid  input  1  execute resolved a taken branch/jump this cycle
- RedirectTarget  input  dataW  new PC for the redirect
- ProgAddr  output  dataW  current PC, to the instruction cache
- IfIdIns  output  dataW  instruction presented to the decoder
- IfIdPC  output  dataW  PC of IfIdIns
- IfIdValid  output  1  IfIdIns is a real fetched instruction
- MisalignFault  output  1  sticky; a redirect target had bits [1:0] != 0

Behaviour:
- Reset (synchronous, active-high, sampled on rising clock edge): ProgAddr=ResetVector, IfIdIns=32'h00000013 (NOP, addi x0,x0,0), IfIdPC=0, IfIdValid=0, MisalignFault=0. Reset mid-redirect or mid-stall discards all pending state.
- PC next-state priority, highest first:
  1. RedirectValid.
     - RedirectTarget[1:0]==0: ProgAddr<=RedirectTarget.
     - Otherwise: MisalignFault<=1, ProgAddr<=ResetVector.
  2. DecodeHold or InsCacheStall: ProgAddr holds.
  3. Otherwise: ProgAddr<=ProgAddr+4, modulo 2^dataW (32'hFFFFFFFC wraps to 0).
- IF/ID next-state priority, highest first:
  1. RedirectValid: flush; IfIdIns<=NOP, IfIdValid<=0, IfIdPC<=0. Applies even when DecodeHold is also high.
  2. DecodeHold: IfIdIns, IfIdPC and IfIdValid all hold.
  3. InsCacheStall: bubble; IfIdIns<=NOP, IfIdValid<=0, IfIdPC holds.
  4. Otherwise: IfIdIns<=InsIn, IfIdPC<=ProgAddr, IfIdValid<=1.
- Latency:
  - An instruction appears on IfIdIns one cycle after its address is on ProgAddr with no stall or hold.
  - After a redirect, the first target instruction reaches IF/ID two cycles later, assuming no cache stall.
- ProgAddr is always word aligned; bits [1:0] are never driven nonzero.
- MisalignFault clears only on reset.
- InsIn is never sampled while InsCacheStall=1.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN
- Defined:
  - Adds output FetchCount (32b): increments on every IF/ID load with IfIdValid<=1.
  - Adds output StallCount (32b): increments on every cycle InsCacheStall=1 while not in reset.
  - Both counters reset to 0 and wrap silently at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 4 free-running cycles, ResetVector=0, InsIn=0xA0+PC -> ProgAddr 0,4,8,12,16; IfIdPC 0,4,8 with IfIdValid=1 from cycle 2; IfIdIns=0xA0,0xA4,0xA8.
- InsCacheStall high 3 cycles at ProgAddr=0x40 -> ProgAddr stays 0x40; IfIdIns=0x00000013, IfIdValid=0 for those cycles; ProgAddr=0x44 the cycle after stall drops.
- DecodeHold high 2 cycles with IfIdPC=0x10 -> IfIdPC/IfIdIns unchanged, ProgAddr frozen; resumes at +4 after release.
- RedirectValid with RedirectTarget=0x200 and DecodeHold=1 in the same cycle -> next cycle ProgAddr=0x200, IfIdValid=0, IfIdIns=NOP; next cycle IfIdPC=0x200, IfIdValid=1.
- RedirectTarget=0x202 -> MisalignFault=1 and stays 1; ProgAddr=ResetVector; reset clears MisalignFault.
- ProgAddr=0xFFFFFFFC, no stall -> next ProgAddr=0x00000000. With FETCH_PERF_CNT_EN: FetchCount and StallCount match the counts from the preceding scenarios.
